int_rec: RTL

- Inverse of the `dev` differencing stage: a saturating integrator that rebuilds the signed sample stream from its first-difference stream (`D_out` → `SP_rec`).
- Sits on the receive/reconstruct side of the Level1 datapath, downstream of any link or buffer carrying `D` samples.
- Valid/ready on both sides, a one-entry registered output, preload for the initial value, a sticky saturation flag and an accepted-sample counter.

---
 rtl/int_rec.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/int_rec.sv
// ---------------------------------------------------------------------------
// int_rec : saturating integrator that rebuilds a signed sample stream from
//           its first-difference stream (inverse of the differencing stage).
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   D_in         signed difference sample (W bits)
//   D_valid      D_in is valid this cycle
//   D_ready      block can accept D_in this cycle (combinational)
//   preload      load accumulator from preload_val, clear stream/flags/count
//   preload_val  signed initial accumulator value (W bits)
//   SP_rec       signed reconstructed sample (registered, W bits)
//   SP_valid     SP_rec holds an unconsumed result
//   out_ready    downstream consumes SP_rec this cycle
//   sat          sticky flag: some accumulation was clamped
//   cnt          accepted samples since reset/preload, saturating (CNT_W bits)
// ---------------------------------------------------------------------------
module int_rec #(
    parameter int W     = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     D_in,
    input  logic             D_valid,
    output logic             D_ready,
    input  logic             preload,
    input  logic [W-1:0]     preload_val,
    output logic [W-1:0]     SP_rec,
    output logic             SP_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [W-1:0]     MAX_V   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     MIN_V   = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Signed add in W+1 bits with clamping; returns {clamped, result}.
    // Overflow shows as a disagreement between the two top sum bits; the
    // extra (true sign) bit tells which rail to clamp to.
    function automatic logic [W:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            if (sum[W] == 1'b0) begin
                sat_add = {1'b1, MAX_V};
            end else begin
                sat_add = {1'b1, MIN_V};
            end
        end else begin
            sat_add = {1'b0, sum[W-1:0]};
        end
    endfunction

    state_t           state_r, state_s;
    logic [W-1:0]     acc_r, acc_s;
    logic [W-1:0]     sp_rec_r, sp_rec_s;
    logic             sat_r, sat_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ready_s;
    logic             accept_s;
    logic [W:0]       add_s;

    // Handshake decode: ready never looks at D_valid, so upstream may wait on it.
    always_comb begin
        ready_s  = !preload && ((state_r == EMPTY) || out_ready);
        accept_s = D_valid && ready_s;
        add_s    = sat_add(acc_r, D_in);
    end

    // Next-state and next-data logic; preload outranks accept, which outranks consume.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        sp_rec_s = sp_rec_r;
        sat_s    = sat_r;
        cnt_s    = cnt_r;
        if (preload) begin
            state_s  = EMPTY;
            acc_s    = preload_val;
            sp_rec_s = preload_val;
            sat_s    = 1'b0;
            cnt_s    = {CNT_W{1'b0}};
        end else if (accept_s) begin
            // A simultaneous consume is absorbed here: the slot refills at once.
            state_s  = FULL;
            acc_s    = add_s[W-1:0];
            sp_rec_s = add_s[W-1:0];
            sat_s    = sat_r | add_s[W];
            if (cnt_r == CNT_MAX) begin
                cnt_s = cnt_r;
            end else begin
                cnt_s = cnt_r + CNT_ONE;
            end
        end else begin
            case (state_r)
                FULL: begin
                    if (out_ready) begin
                        state_s = EMPTY;
                    end else begin
                        state_s = FULL;
                    end
                end
                EMPTY:   state_s = EMPTY;
                default: state_s = EMPTY;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= EMPTY;
            acc_r    <= {W{1'b0}};
            sp_rec_r <= {W{1'b0}};
            sat_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            sp_rec_r <= sp_rec_s;
            sat_r    <= sat_s;
            cnt_r    <= cnt_s;
        end
    end

    assign D_ready  = ready_s;
    assign SP_rec   = sp_rec_r;
    assign SP_valid = (state_r == FULL);
    assign sat      = sat_r;
    assign cnt      = cnt_r;

endmodule
